// File: rtl/debounce_sync.sv
// Debounces a raw button/switch level into a registered level plus one-cycle rise/fall pulses.
// Optional two-flop input synchronizer enabled by defining DEBOUNCE_SYNC_EN.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned TW = (STABLE_CYCLES + 1 > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ZERO      = 2'd0,
    WAIT_ONE  = 2'd1,
    ONE       = 2'd2,
    WAIT_ZERO = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  assign s = sync[1];
`else
  assign s = btn;
`endif

  // db changes on the same edge that leaves a WAIT state, so it is never a decode of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ZERO;
      timer <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ZERO: begin
          if (s) begin
            state <= WAIT_ONE;
            timer <= TLOAD;
          end
        end
        WAIT_ONE: begin
          if (!s) begin
            state <= ZERO;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= ONE;
            db    <= 1'b1;
            rise  <= 1'b1;
          end
        end
        ONE: begin
          if (!s) begin
            state <= WAIT_ZERO;
            timer <= TLOAD;
          end
        end
        WAIT_ZERO: begin
          if (s) begin
            state <= ONE;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= ZERO;
            db    <= 1'b0;
            fall  <= 1'b1;
          end
        end
        default: begin
          state <= ZERO;
          timer <= '0;
          db    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model predicts db/rise/fall each cycle.
module tb_debounce_sync;

  localparam int unsigned SC = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic db, rise, fall;

  debounce_sync #(.STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .db  (db),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  logic [2:0]  expq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          active = 1'b0;
  int unsigned cyc = 0;

  // Reference model: the sampled input is btn delayed by the synchronizer depth;
  // db flips once SC+1 consecutive samples disagree with it.
  logic        m_db = 1'b0;
  int unsigned m_run = 0;
  logic        m_p0 = 1'b0, m_p1 = 1'b0;

  task automatic step(input logic r, input logic b);
    logic s, mr, mf;
    @(negedge clk);
    rst = r;
    btn = b;
    mr  = 1'b0;
    mf  = 1'b0;
    if (!r) begin
      m_db  = 1'b0;
      m_run = 0;
      m_p0  = 1'b0;
      m_p1  = 1'b0;
    end else begin
      if (SYNC) begin
        s    = m_p1;
        m_p1 = m_p0;
        m_p0 = b;
      end else begin
        s = b;
      end
      if (s != m_db) begin
        m_run++;
        if (m_run == SC + 1) begin
          m_db  = s;
          mr    = s;
          mf    = !s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    active = 1'b1;
    expq.push_back({m_db, mr, mf});
  endtask

  task automatic hold(input logic b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1, b);
  endtask

  // Monitor: outputs are valid every cycle; compare each against the queued prediction.
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (active) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL queue_empty cycle %0d: got db/rise/fall=%b%b%b, no prediction available", cyc, db, rise, fall);
        end else begin
          e = expq.pop_front();
          if ({db, rise, fall} !== e) begin
            n_bad++;
            $display("FAIL outs cycle %0d: got db/rise/fall=%b%b%b required %b", cyc, db, rise, fall, e);
          end
        end
        n_cmp++;
        if (rise && fall) begin
          n_bad++;
          $display("FAIL rise_fall_excl cycle %0d: got rise=%b fall=%b required not both 1", cyc, rise, fall);
        end
      end
    end
  end

  initial begin
    logic lvl;
    int unsigned len;
    // Reset then idle low
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0);
    hold(1'b0, 20);
    // Clean rise
    hold(1'b1, 15);
    // Clean fall, then a 4-cycle high pulse that must be ignored
    hold(1'b0, 15);
    hold(1'b1, 4);
    hold(1'b0, 10);
    // Bounce then hold
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1);
    hold(1'b1, 12);
    // 3-cycle low glitch from db=1, then a real fall
    hold(1'b0, 3);
    hold(1'b1, 10);
    hold(1'b0, 12);
    // Reset mid-qualification with btn held high
    hold(1'b1, 5);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1);
    hold(1'b1, 12);
    // Exact-threshold runs around SC+1
    hold(1'b0, 12);
    hold(1'b1, SC);
    hold(1'b0, 8);
    hold(1'b1, SC + 1);
    hold(1'b0, 10);
    // Randomized segments with occasional resets
    lvl = 1'b0;
    for (int unsigned k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        len = $urandom_range(1, 3);
        for (int unsigned i = 0; i < len; i++) step(1'b0, 1'($urandom_range(0, 1)));
      end
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      hold(lvl, len);
    end
    hold(lvl, 10);
    @(posedge clk);
    #2;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unconsumed predictions required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Conditions a raw, asynchronous push-button or switch level into a clean, synchronous, debounced level with single-cycle edge pulses. It sits directly upstream of the edge/delay detector stages and drives their `sig` input from `db`. Its `rise` and `fall` pulses serve consumers that need edges without a separate detector. A four-state FSM with a down-counter qualifies each level change. A change is accepted only after the input has been stable for `STABLE_CYCLES + 1` consecutive sampled cycles.

## Interface
- `STABLE_CYCLES`, default 20: extra stable cycles required after the first differing sample. Legal range is ≥ 1.
- `clk` input, 1 bit: single clock. All logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset. Asserting it (0) resets immediately; release is synchronous to `clk`.
- `btn` input, 1 bit: raw input level. May be asynchronous to `clk` when `DEBOUNCE_SYNC_EN` is defined.
- `db` output, 1 bit: debounced level, registered.
- `rise` output, 1 bit: one-cycle pulse, registered, high in the first cycle `db` reads 1.
- `fall` output, 1 bit: one-cycle pulse, registered, high in the first cycle `db` reads 0.

## Operation
- Sampled input `s`:
  - With `DEBOUNCE_SYNC_EN` defined, `s` is `btn` after two flops.
  - Without it, `s` is `btn` directly.
- Timer width is `$clog2(STABLE_CYCLES+1)`. The timer is unsigned, loads `STABLE_CYCLES-1`, decrements by 1, and never wraps below 0.
- State `ZERO` (`db`=0):
  - `s`=1 → go to `WAIT_ONE` and load the timer.
- State `WAIT_ONE` (`db`=0):
  - `s`=0 → go to `ZERO`. The bounce is discarded.
  - Otherwise, timer≠0 → decrement.
  - Otherwise, timer=0 → go to `ONE`, with `db`←1 and `rise`←1 on the same edge.
- State `ONE` (`db`=1):
  - `s`=0 → go to `WAIT_ZERO` and load the timer.
- State `WAIT_ZERO` (`db`=1):
  - `s`=1 → go to `ONE`.
  - Otherwise, timer≠0 → decrement.
  - Otherwise, timer=0 → go to `ZERO`, with `db`←0 and `fall`←1.
- `rise` and `fall` are never high together. Each is high for exactly one cycle per accepted transition.
- A bounce during a WAIT state restarts qualification from the stable state. Any run of `s` shorter than `STABLE_CYCLES+1` cycles has no effect on the outputs.
- A reversion on the same cycle the timer reaches 0 wins: the FSM returns to the stable state and emits no pulse.

## Timing
- Reset values:
  - Outputs: `db`=0, `rise`=0, `fall`=0.
  - Internal: state `ZERO`, timer 0, synchronizer flops 0.
- Reset mid-qualification aborts it. No pulse is emitted.
- First-cycle timing: if `s` first reads 1 in `ZERO` at cycle k and stays 1 through cycle k+`STABLE_CYCLES`, then `db`=1 and `rise`=1 at cycle k+`STABLE_CYCLES`+1.
- Latency from the `btn` edge to the `db` change:
  - `STABLE_CYCLES`+3 cycles with `DEBOUNCE_SYNC_EN` defined.
  - `STABLE_CYCLES`+1 cycles without it.
- The fall path is symmetric.
- `btn` held constant from reset at 1 produces `rise` after the rise latency. No pulse is suppressed at startup.

## Configuration
- `DEBOUNCE_SYNC_EN` defined:
  - A two-flop synchronizer is inserted on `btn`.
  - `btn` may be fully asynchronous.
  - Latency increases by 2 cycles.
- `DEBOUNCE_SYNC_EN` undefined:
  - `btn` feeds the FSM directly.
  - `btn` must be synchronous to `clk`.
  - FSM and counter behaviour are otherwise identical.

## Test plan
All cases use `STABLE_CYCLES`=4 with `DEBOUNCE_SYNC_EN` defined.

1. Reset, then `btn`=0 for 20 cycles → `db`=0 throughout, no `rise` or `fall`.
2. `btn`: 0→1 at cycle 10, held → `db`=1 and `rise`=1 at cycle 17 only; `rise`=0 at cycle 18.
3. `btn` high for 4 cycles, then low → `db` stays 0, no `rise`.
4. `btn` bounces (1,0,1,1,0,1), then holds 1 → `rise` occurs exactly 7 cycles after the final 0→1 edge, once only.
5. From `db`=1, `btn`→0 held → `fall`=1 and `db`=0 exactly 7 cycles later; a 3-cycle low glitch instead leaves `db`=1.
6. Assert `rst`=0 while in `WAIT_ONE` with the timer at 2, release, `btn` still 1 → no pulse during or after reset until a full 7-cycle qualification completes.
